// File: rtl/ms_tick_bcd_counter.sv
// Millisecond BCD accumulator with a run/pause/clear controller, fed by the 1 ms prescaler tick.
// Optional lap-freeze display hold is enabled by defining MS_COUNTER_LAP_EN.

module ms_tick_bcd_counter #(
    parameter int NDIG = 4,
    parameter bit WRAP = 1'b0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              TICK,
    input  logic              START,
    input  logic              STOP,
    input  logic              CLR,
`ifdef MS_COUNTER_LAP_EN
    input  logic              LAP,
    output logic              LAPPED,
`endif
    output logic [4*NDIG-1:0] BCD,
    output logic              RUNNING,
    output logic              OVF
);

    localparam int W = 4 * NDIG;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [W-1:0]   count_q;
    logic [W-1:0]   count_d;
    logic [W-1:0]   count_inc;
    logic           all_nines;
    logic           tick_run;
    logic           ovf_q;
    logic           ovf_d;
    logic           running_q;

    // Ripple-carry BCD increment; a carry surviving the top digit means the count was all nines.
    always_comb begin : incrementer
        logic carry;
        carry     = 1'b1;
        count_inc = count_q;
        for (int i = 0; i < NDIG; i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
        all_nines = carry;
    end

    assign tick_run = (state_q == RUN) && TICK;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (CLR) begin
            state_d = IDLE;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            if (tick_run) begin
                if (all_nines) begin
                    ovf_d = 1'b1;
                    if (WRAP) begin
                        count_d = '0;
                    end else begin
                        state_d = PAUSE;
                    end
                end else begin
                    count_d = count_inc;
                end
            end
            // A tick in the START cycle is not counted because tick_run looks at the old state.
            if (STOP && (state_q == RUN)) begin
                state_d = PAUSE;
            end else if (START && (state_q != RUN)) begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            running_q <= (state_d == RUN);
        end
    end

    assign RUNNING = running_q;
    assign OVF     = ovf_q;

`ifdef MS_COUNTER_LAP_EN
    logic         lap_q;
    logic         lap_d;
    logic [W-1:0] disp_q;
    logic [W-1:0] disp_d;

    // The display register follows the live count except while a lap freeze is held.
    always_comb begin
        lap_d = lap_q;
        if (lap_q) begin
            if (LAP || STOP || CLR) begin
                lap_d = 1'b0;
            end
        end else if (LAP && (state_q == RUN) && !STOP && !CLR) begin
            lap_d = 1'b1;
        end
        disp_d = (lap_q && lap_d) ? disp_q : count_d;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lap_q  <= 1'b0;
            disp_q <= '0;
        end else begin
            lap_q  <= lap_d;
            disp_q <= disp_d;
        end
    end

    assign BCD    = disp_q;
    assign LAPPED = lap_q;
`else
    assign BCD = count_q;
`endif

endmodule

// File: doc/ms_tick_bcd_counter.md
Name: ms_tick_bcd_counter

Overview:
- Consumer end of the 1 ms tick interface. Takes the single-cycle tick from the prescaler terminal-count comparator and accumulates elapsed milliseconds as packed BCD digits.
- Small run/pause/clear state machine driven by synchronised, debounced button pulses.
- Sits between the prescaler/comparator pair and the 7-segment display multiplexer.

Parameters:
- NDIG, 4, number of BCD digits; maximum count is 10^NDIG-1 (9999 ms at default).
- WRAP, 0, overflow policy: 1 = roll over to all-zero; 0 = saturate at all-nines.

Ports:
- CLK  input  1  system clock, 100 MHz.
- RST  input  1  asynchronous, active-high reset.
- TICK  input  1  1 ms strobe, high for exactly one CLK cycle per period, registered upstream.
- START  input  1  single-cycle pulse: begin or resume counting.
- STOP  input  1  single-cycle pulse: pause counting.
- CLR  input  1  single-cycle pulse: zero the count.
- BCD  output  4*NDIG  packed digits; [3:0] is the ms units digit. Registered.
- RUNNING  output  1  high in state RUN. Registered.
- OVF  output  1  sticky overflow flag. Registered.

Behaviour:
- Reset (RST high, asynchronous): BCD=0, RUNNING=0, OVF=0, state=IDLE. Any operation in progress is abandoned immediately.
- States: IDLE (count zero, stopped), RUN, PAUSE (count held, nonzero or zero).
- Transitions:
  - IDLE --START--> RUN.
  - RUN --STOP--> PAUSE.
  - PAUSE --START--> RUN.
  - Any state --CLR--> IDLE. CLR zeroes BCD and OVF.
- Control priority within one cycle: CLR > STOP > START. CLR+START in the same cycle gives IDLE with BCD=0.
- Increment:
  - Happens only when state is RUN at the clock edge where TICK=1.
  - BCD updates at that edge, so BCD is visible one cycle after the TICK cycle.
- Same-cycle events:
  - TICK in the same cycle as STOP (while in RUN): the tick is counted, then the state moves to PAUSE.
  - TICK in the same cycle as START (from IDLE or PAUSE): the tick is not counted; counting begins with the next tick.
  - TICK in the same cycle as CLR: the tick is discarded.
- BCD arithmetic: ripple-carry per digit. A digit equal to 9 with carry-in becomes 0 and carries out; otherwise digit+carry. No binary-to-BCD conversion.
- Terminal count (all digits 9) with TICK in RUN:
  - WRAP=1: BCD becomes 0, OVF set to 1, state stays RUN.
  - WRAP=0: BCD holds at all-nines, OVF set to 1, state goes to PAUSE (RUNNING drops the next cycle).
- OVF stays set until CLR or RST.
- RUNNING is the registered state decode; it goes high the cycle after the START edge.
- START while in RUN and STOP while in IDLE/PAUSE are ignored (no state change).
- TICK is ignored in IDLE and PAUSE.

Optional Feature:
- Macro: MS_COUNTER_LAP_EN.
- Defined:
  - Adds input LAP (single-cycle pulse) and output LAPPED (1 bit).
  - LAP in RUN freezes BCD at the current count, including any increment in the same cycle, and sets LAPPED=1. The internal count keeps advancing.
  - A second LAP, STOP, or CLR releases the freeze. BCD then resumes showing the live count on the next cycle and LAPPED returns to 0.
  - LAP outside RUN is ignored.
  - OVF tracks the live count, not the frozen display.
- Undefined: no LAP/LAPPED ports, BCD always shows the live count, and no extra registers are inferred.

Test Plan:
- Reset then START, 1234 TICK pulses with 5 idle cycles between each -> BCD=16'h1234, RUNNING=1, OVF=0.
- In RUN, STOP at count 0042, then 10 TICKs, then START and 3 TICKs -> BCD holds 16'h0042 during pause, ends at 16'h0045.
- WRAP=0: preload by 9999 TICKs, then 1 more TICK -> BCD=16'h9999, OVF=1, RUNNING=0 next cycle. WRAP=1 with the same stimulus -> BCD=16'h0000, OVF=1, RUNNING=1.
- Simultaneous events:
  - TICK+STOP at count 0007 -> BCD=16'h0008, PAUSE.
  - TICK+CLR -> BCD=0, IDLE.
  - TICK+START from IDLE -> BCD stays 0.
- Assert RST asynchronously mid-count at 16'h0500, away from any CLK edge -> all outputs 0 immediately. After release, START and 1 TICK -> 16'h0001.
- MS_COUNTER_LAP_EN defined: LAP at count 0100, then 50 TICKs -> BCD=16'h0100 and LAPPED=1. Second LAP -> BCD=16'h0150 and LAPPED=0 the next cycle.
